// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, captures ROM reads into a PC-tagged FIFO and
// hands them to decode over valid/ready. Optional perf counters: FETCH_PERF_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [31:0]                  imem_addr,
  input  logic [31:0]                  imem_rd,
  input  logic                         imem_sssrc,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc,
  output logic                         out_ss,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  perf_full_cycles,
  output logic [31:0]                  perf_flushes
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic        ss;
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   fetch_pc;
  logic          pop;
  logic          push;
  logic          full;
  logic          redirect_pc_unused;

  // Word alignment is forced, so the low redirect bits carry no information.
  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign full      = (count == FULL_COUNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // Pushing while full is fine when the head leaves this cycle: the write lands
  // in the slot being vacated.
  assign push      = !redirect_valid & (!full | pop);

  assign imem_addr = fetch_pc;
  assign head      = mem[rd_ptr];
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_ss    = head.ss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // NOTE: FIFO storage has no reset; validity is tracked by count, so stale
  // contents are never observed and the array can map to plain RAM cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{ss: imem_sssrc, instr: imem_rd, pc: fetch_pc};
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] full_cycles_q;
  logic [31:0] flushes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cycles_q <= '0;
      flushes_q     <= '0;
    end else begin
      if (full && !pop && (full_cycles_q != '1)) begin
        full_cycles_q <= full_cycles_q + 32'd1;
      end
      if (redirect_valid && (flushes_q != '1)) begin
        flushes_q <= flushes_q + 32'd1;
      end
    end
  end

  assign perf_full_cycles = full_cycles_q;
  assign perf_flushes     = flushes_q;
`else
  assign perf_full_cycles = 32'd0;
  assign perf_flushes     = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ROM model, vector table and reset sequences.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        imem_sssrc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ss;
  logic [2:0]  count;
  logic [31:0] perf_full_cycles;
  logic [31:0] perf_flushes;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_1000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_rd          (imem_rd),
    .imem_sssrc       (imem_sssrc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .out_ss           (out_ss),
    .count            (count),
    .perf_full_cycles (perf_full_cycles),
    .perf_flushes     (perf_flushes)
  );

  // ROM model: four real words at 0x1000, a recognisable pattern elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'hFFC4_A303;
      32'h0000_1004: return 32'h0064_A423;
      32'h0000_1008: return 32'h0062_E233;
      32'h0000_100C: return 32'hFE42_0AE3;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  always_comb begin
    imem_rd    = rom(imem_addr);
    imem_sssrc = (imem_addr == 32'h0000_1008);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        ess;
    int          ecnt;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                     input logic ess, input int ecnt, input logic [31:0] eaddr);
    vec_t v;
    v = '{rv, rpc, rdy, ev, epc, einstr, ess, ecnt, eaddr};
    vecs.push_back(v);
  endtask

  initial begin
    int cyc;
    string tag;

    // Expected outputs are sampled at a falling edge; inputs then apply to the
    // following rising edge.
    //   rv rpc            rdy  ev epc            instr          ss cnt addr
    add(0, 32'h0,          1,   0, 32'h0,         32'h0,         0, 0, 32'h0000_1000);
    add(0, 32'h0,          1,   1, 32'h0000_1000, 32'hFFC4_A303, 0, 1, 32'h0000_1004);
    add(0, 32'h0,          1,   1, 32'h0000_1004, 32'h0064_A423, 0, 1, 32'h0000_1008);
    add(0, 32'h0,          0,   1, 32'h0000_1008, 32'h0062_E233, 1, 1, 32'h0000_100C);
    add(0, 32'h0,          0,   1, 32'h0000_1008, 32'h0062_E233, 1, 2, 32'h0000_1010);
    add(0, 32'h0,          0,   1, 32'h0000_1008, 32'h0062_E233, 1, 3, 32'h0000_1014);
    add(0, 32'h0,          0,   1, 32'h0000_1008, 32'h0062_E233, 1, 4, 32'h0000_1018);
    add(0, 32'h0,          0,   1, 32'h0000_1008, 32'h0062_E233, 1, 4, 32'h0000_1018);
    add(0, 32'h0,          1,   1, 32'h0000_1008, 32'h0062_E233, 1, 4, 32'h0000_1018);
    add(0, 32'h0,          1,   1, 32'h0000_100C, 32'hFE42_0AE3, 0, 4, 32'h0000_101C);
    add(1, 32'h0000_1002,  1,   1, 32'h0000_1010, 32'hA5A5_1010, 0, 4, 32'h0000_1020);
    add(0, 32'h0,          1,   0, 32'h0,         32'h0,         0, 0, 32'h0000_1000);
    add(1, 32'hFFFF_FFFC,  1,   1, 32'h0000_1000, 32'hFFC4_A303, 0, 1, 32'h0000_1004);
    add(0, 32'h0,          1,   0, 32'h0,         32'h0,         0, 0, 32'hFFFF_FFFC);
    add(0, 32'h0,          1,   1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 0, 1, 32'h0000_0000);
    add(0, 32'h0,          0,   1, 32'h0000_0000, 32'hA5A5_0000, 0, 1, 32'h0000_0004);
    add(1, 32'h0000_2003,  1,   1, 32'h0000_0000, 32'hA5A5_0000, 0, 2, 32'h0000_0008);
    add(0, 32'h0,          0,   0, 32'h0,         32'h0,         0, 0, 32'h0000_2000);
    add(0, 32'h0,          1,   1, 32'h0000_2000, 32'hA5A5_2000, 0, 1, 32'h0000_2004);

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_addr", imem_addr, 32'h0000_1000);
    check("reset_perf_full", perf_full_cycles, 32'd0);
    check("reset_perf_flush", perf_flushes, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      tag = $sformatf("v%0d", i);
      check({tag, "_valid"}, 32'(out_valid), 32'(vecs[i].ev));
      check({tag, "_count"}, 32'(count), 32'(vecs[i].ecnt));
      check({tag, "_addr"}, imem_addr, vecs[i].eaddr);
      if (vecs[i].ev) begin
        check({tag, "_pc"}, out_pc, vecs[i].epc);
        check({tag, "_instr"}, out_instr, vecs[i].einstr);
        check({tag, "_ss"}, 32'(out_ss), 32'(vecs[i].ess));
      end
      rst_n          = 1'b1;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
    end

    @(negedge clk);
`ifdef FETCH_PERF_EN
    check("perf_flushes", perf_flushes, 32'd3);
    check("perf_full_cycles", perf_full_cycles, 32'd2);
`else
    check("perf_flushes_off", perf_flushes, 32'd0);
    check("perf_full_cycles_off", perf_full_cycles, 32'd0);
`endif

    // Fill a little, then assert reset between clock edges.
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_count", 32'(count), 32'd0);
    check("async_reset_addr", imem_addr, 32'h0000_1000);
    check("async_reset_perf", perf_flushes, 32'd0);

    // First valid must appear exactly one cycle after release.
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc       = 0;
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
    check("release_latency", 32'(cyc), 32'd1);
    check("release_pc", out_pc, 32'h0000_1000);
    check("release_instr", out_instr, 32'hFFC4_A303);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
